execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute stage of the 16-bit pipelined CPU. Sits between decode and the memory stage.
- Resolves operand forwarding from the memory and writeback stages, computes ALU results, load/store addresses and store data, and resolves beq/jalr branches.
- Detects load-use hazards and holds a halt latch that kills younger instructions.
- Registers {opcode, tgt, result, halt, bubble} plus store data for the memory stage.

Parameters:
- WIDTH, 16, datapath width; all arithmetic is mod 2^WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- bubble_in  in  1  decode slot is empty
- halt_in  in  1  decode instruction is a halt
- halt_in_wb  in  1  halt has reached writeback; squash
- opcode_in  in  3  000 add, 001 addi, 010 nand, 011 lui, 100 sw, 101 lw, 110 beq, 111 jalr
- tgt_in  in  3  destination register
- s1_in, s2_in  in  3  source register ids (A, B)
- op1_in, op2_in  in  16  register-file values for s1/s2
- imm_in  in  16  immediate, already sign-extended (lui: already shifted)
- pc_in  in  16  instruction address
- mem_opcode, mem_tgt  in  3  instruction currently in memory stage
- mem_result  in  16  memory-stage result
- mem_bubble  in  1  memory-stage slot empty
- wb_we  in  1  writeback writing this cycle
- wb_tgt  in  3  writeback destination
- wb_data  in  16  writeback data
- stall_out  out  1  combinational load-use stall to decode/fetch
- branch_taken  out  1  combinational redirect/flush of fetch and decode
- branch_target  out  16  combinational redirect address
- opcode_out, tgt_out  out  3  registered
- result_out  out  16  registered ALU result / memory address
- store_data_out  out  16  registered sw data
- bubble_out, halt_out  out  1  registered

Behaviour:
- Valid instruction: valid = !bubble_in && !halted && !halt_in_wb && !stall_out.
- Operand resolution, per source s (A from s1/op1, B from s2/op2):
  - s==0 -> 0.
  - Else if !mem_bubble && mem_tgt==s && mem_opcode!=101 -> mem_result.
  - Else if wb_we && wb_tgt==s -> wb_data.
  - Else the register-file value.
  - Memory stage has priority over writeback.
- Load-use stall: stall_out = !bubble_in && !halted && !mem_bubble && mem_opcode==101 && mem_tgt!=0 && (mem_tgt==s1_in || mem_tgt==s2_in).
  - On stall, decode holds its instruction and this stage issues a bubble.
- Result by opcode:
  - add: A+B
  - addi: A+imm
  - nand: ~(A&B)
  - lui: imm
  - sw / lw: A+imm (address)
  - beq: 0
  - jalr: pc_in+1
- tgt_out is forced to 0 for sw and beq. store_data_out = B for sw, 0 otherwise.
- Branches, only when valid:
  - beq taken when A==B; branch_target = pc_in+1+imm (wrap mod 2^16).
  - jalr always taken; branch_target = B.
  - Otherwise branch_taken=0 and branch_target=0.
- Halt latch:
  - When valid && halt_in, halt_out=1 on the next edge and halted is set.
  - halted stays set until reset; while set, bubble_out=1 and branch_taken=0.
- Register update at each posedge:
  - bubble_out <= !valid.
  - halt_out <= valid && halt_in.
  - All other outputs load the computed values when valid. When !valid they load zero.
- Reset (rst_n=0 at posedge): bubble_out=1, halt_out=0, every other output=0, halted=0. Reset overrides any simultaneous input.
- Latency: one cycle from decode to memory stage. stall_out, branch_taken and branch_target are same-cycle.
- Simultaneous events: halt_in_wb overrides stall, branch and halt. A stall suppresses any branch from the stalled instruction.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release with bubble_in=1 -> bubble_out=1, halt_out=0, result_out=0, stall_out=0.
- Forwarding: add with s1=2, s2=3, op1=5, op2=7, mem_tgt=2 with mem_result=0x0010 (mem_opcode add), wb_we=1 with wb_tgt=3 and wb_data=0x0004 -> result_out=0x0014 next cycle. Repeat with s1=0 and mem_tgt=0 -> A=0.
- Load-use: mem_opcode=101, mem_tgt=4, mem_bubble=0, incoming add with s2=4 -> stall_out=1 and bubble_out=1 next cycle. The following cycle (mem_bubble=1, wb forwarding of r4) -> instruction issues correctly.
- Branches:
  - beq with A=B=9, pc=0x0010, imm=0xFFFE -> branch_taken=1, branch_target=0x000F, tgt_out=0.
  - jalr with B=0x1234, pc=0xFFFF -> target 0x1234, result_out=0x0000 (wrap).
- Store: sw with A=0x0100, imm=3, B=0xBEEF -> result_out=0x0103, store_data_out=0xBEEF, tgt_out=0.
- Halt: valid halt_in -> halt_out=1 next cycle. Subsequent valid adds -> bubble_out=1. Asserting halt_in_wb together with a taken beq -> branch_taken=0.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: forwarding, ALU, branch resolution, load-use stall and halt latch of the 16-bit CPU
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   bubble_in, halt_in, halt_in_wb  decode slot empty, decode halt, halt reached writeback
//   opcode_in, tgt_in, s1_in, s2_in decode instruction fields
//   op1_in, op2_in, imm_in, pc_in   register values, immediate, instruction address
//   mem_opcode, mem_tgt, mem_result, mem_bubble  memory-stage instruction
//   wb_we, wb_tgt, wb_data          writeback port
//   stall_out, branch_taken, branch_target       same-cycle control to fetch/decode
//   opcode_out, tgt_out, result_out, store_data_out, bubble_out, halt_out  registered to memory stage
module execute_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bubble_in,
  input  logic             halt_in,
  input  logic             halt_in_wb,
  input  logic [2:0]       opcode_in,
  input  logic [2:0]       tgt_in,
  input  logic [2:0]       s1_in,
  input  logic [2:0]       s2_in,
  input  logic [WIDTH-1:0] op1_in,
  input  logic [WIDTH-1:0] op2_in,
  input  logic [WIDTH-1:0] imm_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [2:0]       mem_opcode,
  input  logic [2:0]       mem_tgt,
  input  logic [WIDTH-1:0] mem_result,
  input  logic             mem_bubble,
  input  logic             wb_we,
  input  logic [2:0]       wb_tgt,
  input  logic [WIDTH-1:0] wb_data,
  output logic             stall_out,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_target,
  output logic [2:0]       opcode_out,
  output logic [2:0]       tgt_out,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] store_data_out,
  output logic             bubble_out,
  output logic             halt_out
);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;
  logic             halted_q, halted_d;
  logic [2:0]       opcode_q, opcode_d, tgt_q, tgt_d;
  logic [WIDTH-1:0] result_q, result_d, store_q, store_d;
  logic             bubble_q, bubble_d, halt_q, halt_d;
  logic [WIDTH-1:0] a, b, pc_inc, alu;
  logic             valid, mem_fwd_ok, is_beq, is_jalr, is_sw, eq;
  // A loaded value is not yet available in the memory stage, so it is never forwarded from there
  assign mem_fwd_ok = !mem_bubble && mem_opcode != OP_LW;
  assign a = (s1_in == 3'd0) ? '0 :
             (mem_fwd_ok && mem_tgt == s1_in) ? mem_result :
             (wb_we && wb_tgt == s1_in) ? wb_data : op1_in;
  assign b = (s2_in == 3'd0) ? '0 :
             (mem_fwd_ok && mem_tgt == s2_in) ? mem_result :
             (wb_we && wb_tgt == s2_in) ? wb_data : op2_in;
  // A squash from writeback outranks the stall as well as branches and halts
  assign stall_out = !bubble_in && !halted_q && !halt_in_wb && !mem_bubble && mem_opcode == OP_LW &&
                     mem_tgt != 3'd0 && (mem_tgt == s1_in || mem_tgt == s2_in);
  assign valid   = !bubble_in && !halted_q && !halt_in_wb && !stall_out;
  assign is_beq  = opcode_in == OP_BEQ;
  assign is_jalr = opcode_in == OP_JALR;
  assign is_sw   = opcode_in == OP_SW;
  assign eq      = a == b;
  assign pc_inc  = pc_in + WIDTH'(1);
  assign branch_taken  = valid && ((is_beq && eq) || is_jalr);
  assign branch_target = !valid ? '0 :
                         (is_beq && eq) ? pc_inc + imm_in :
                         is_jalr ? b : '0;
  always_comb begin
    alu = '0;
    alu = (opcode_in == OP_ADD)  ? a + b :
          (opcode_in == OP_NAND) ? ~(a & b) :
          (opcode_in == OP_LUI)  ? imm_in :
          (opcode_in == OP_BEQ)  ? '0 :
          is_jalr                ? pc_inc : a + imm_in;
  end
  always_comb begin
    opcode_d = valid ? opcode_in : 3'd0;
    tgt_d    = (valid && !is_sw && !is_beq) ? tgt_in : 3'd0;
    result_d = valid ? alu : '0;
    store_d  = (valid && is_sw) ? b : '0;
    bubble_d = !valid;
    halt_d   = valid && halt_in;
    halted_d = halted_q || (valid && halt_in);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
      opcode_q <= '0;
      tgt_q    <= '0;
      result_q <= '0;
      store_q  <= '0;
      bubble_q <= 1'b1;
      halt_q   <= 1'b0;
    end else begin
      halted_q <= halted_d;
      opcode_q <= opcode_d;
      tgt_q    <= tgt_d;
      result_q <= result_d;
      store_q  <= store_d;
      bubble_q <= bubble_d;
      halt_q   <= halt_d;
    end
  end
  assign opcode_out     = opcode_q;
  assign tgt_out        = tgt_q;
  assign result_out     = result_q;
  assign store_data_out = store_q;
  assign bubble_out     = bubble_q;
  assign halt_out       = halt_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n, bubble_in, halt_in, halt_in_wb, mem_bubble, wb_we;
  logic [2:0]  opcode_in, tgt_in, s1_in, s2_in, mem_opcode, mem_tgt, wb_tgt;
  logic [15:0] op1_in, op2_in, imm_in, pc_in, mem_result, wb_data;
  logic        stall_out, branch_taken, bubble_out, halt_out;
  logic [15:0] branch_target, result_out, store_data_out;
  logic [2:0]  opcode_out, tgt_out;
  int          total = 0;
  int          passed = 0;
  always #5 clk = ~clk;
  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .bubble_in(bubble_in), .halt_in(halt_in), .halt_in_wb(halt_in_wb),
    .opcode_in(opcode_in), .tgt_in(tgt_in), .s1_in(s1_in), .s2_in(s2_in),
    .op1_in(op1_in), .op2_in(op2_in), .imm_in(imm_in), .pc_in(pc_in),
    .mem_opcode(mem_opcode), .mem_tgt(mem_tgt), .mem_result(mem_result), .mem_bubble(mem_bubble),
    .wb_we(wb_we), .wb_tgt(wb_tgt), .wb_data(wb_data),
    .stall_out(stall_out), .branch_taken(branch_taken), .branch_target(branch_target),
    .opcode_out(opcode_out), .tgt_out(tgt_out), .result_out(result_out),
    .store_data_out(store_data_out), .bubble_out(bubble_out), .halt_out(halt_out)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [2:0] op, input logic [2:0] tgt, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] imm, input logic [15:0] pc);
    bubble_in = 1'b0;
    opcode_in = op;
    tgt_in = tgt;
    s1_in = s1;
    s2_in = s2;
    op1_in = v1;
    op2_in = v2;
    imm_in = imm;
    pc_in = pc;
  endtask
  initial begin
    rst_n = 1'b0; bubble_in = 1'b1; halt_in = 1'b0; halt_in_wb = 1'b0;
    opcode_in = '0; tgt_in = '0; s1_in = '0; s2_in = '0;
    op1_in = '0; op2_in = '0; imm_in = '0; pc_in = '0;
    mem_opcode = '0; mem_tgt = '0; mem_result = '0; mem_bubble = 1'b1;
    wb_we = 1'b0; wb_tgt = '0; wb_data = '0;
    step;
    step;
    chk("rst_bubble", {15'd0, bubble_out}, 16'd1);
    chk("rst_halt", {15'd0, halt_out}, 16'd0);
    rst_n = 1'b1;
    step;
    chk("idle_bubble", {15'd0, bubble_out}, 16'd1);
    chk("idle_halt", {15'd0, halt_out}, 16'd0);
    chk("idle_result", result_out, 16'h0000);
    chk("idle_stall", {15'd0, stall_out}, 16'd0);
    instr(3'b000, 3'd1, 3'd2, 3'd3, 16'd5, 16'd7, 16'd0, 16'd0);
    mem_bubble = 1'b0; mem_opcode = 3'b000; mem_tgt = 3'd2; mem_result = 16'h0010;
    wb_we = 1'b1; wb_tgt = 3'd3; wb_data = 16'h0004;
    #1;
    chk("fwd_stall", {15'd0, stall_out}, 16'd0);
    chk("fwd_br", {15'd0, branch_taken}, 16'd0);
    step;
    chk("fwd_result", result_out, 16'h0014);
    chk("fwd_tgt", {13'd0, tgt_out}, 16'd1);
    chk("fwd_bubble", {15'd0, bubble_out}, 16'd0);
    chk("fwd_store0", store_data_out, 16'h0000);
    s1_in = 3'd0; mem_tgt = 3'd0;
    step;
    chk("fwd_r0", result_out, 16'h0004);
    s1_in = 3'd2; mem_tgt = 3'd2; wb_tgt = 3'd2; wb_data = 16'h0099;
    step;
    chk("fwd_prio", result_out, 16'h0017);
    mem_bubble = 1'b1; wb_we = 1'b0;
    instr(3'b010, 3'd2, 3'd1, 3'd2, 16'hF0F0, 16'h0FF0, 16'd0, 16'd0);
    step;
    chk("nand", result_out, 16'hFF0F);
    instr(3'b011, 3'd3, 3'd1, 3'd2, 16'h1111, 16'h2222, 16'hAB00, 16'd0);
    step;
    chk("lui", result_out, 16'hAB00);
    instr(3'b001, 3'd3, 3'd1, 3'd0, 16'hFFFF, 16'h0000, 16'h0002, 16'd0);
    step;
    chk("addi_wrap", result_out, 16'h0001);
    chk("addi_op", {13'd0, opcode_out}, 16'd1);
    instr(3'b000, 3'd5, 3'd1, 3'd4, 16'h0001, 16'h0050, 16'd0, 16'd0);
    mem_bubble = 1'b0; mem_opcode = 3'b101; mem_tgt = 3'd4;
    #1;
    chk("lu_stall", {15'd0, stall_out}, 16'd1);
    step;
    chk("lu_bubble", {15'd0, bubble_out}, 16'd1);
    chk("lu_result0", result_out, 16'h0000);
    mem_bubble = 1'b1; wb_we = 1'b1; wb_tgt = 3'd4; wb_data = 16'h0030;
    #1;
    chk("lu_release", {15'd0, stall_out}, 16'd0);
    step;
    chk("lu_result", result_out, 16'h0031);
    chk("lu_tgt", {13'd0, tgt_out}, 16'd5);
    wb_we = 1'b0;
    instr(3'b110, 3'd3, 3'd4, 3'd4, 16'd9, 16'd9, 16'hFFFE, 16'h0010);
    mem_bubble = 1'b0; mem_opcode = 3'b101; mem_tgt = 3'd4;
    #1;
    chk("stall_kills_br", {15'd0, branch_taken}, 16'd0);
    mem_bubble = 1'b1;
    instr(3'b110, 3'd3, 3'd1, 3'd2, 16'd9, 16'd9, 16'hFFFE, 16'h0010);
    #1;
    chk("beq_taken", {15'd0, branch_taken}, 16'd1);
    chk("beq_target", branch_target, 16'h000F);
    step;
    chk("beq_tgt0", {13'd0, tgt_out}, 16'd0);
    chk("beq_result", result_out, 16'h0000);
    op2_in = 16'd8;
    #1;
    chk("beq_nt", {15'd0, branch_taken}, 16'd0);
    chk("beq_nt_target", branch_target, 16'h0000);
    instr(3'b111, 3'd7, 3'd1, 3'd2, 16'h0000, 16'h1234, 16'd0, 16'hFFFF);
    #1;
    chk("jalr_taken", {15'd0, branch_taken}, 16'd1);
    chk("jalr_target", branch_target, 16'h1234);
    step;
    chk("jalr_link", result_out, 16'h0000);
    chk("jalr_tgt", {13'd0, tgt_out}, 16'd7);
    instr(3'b100, 3'd6, 3'd1, 3'd2, 16'h0100, 16'hBEEF, 16'h0003, 16'd0);
    step;
    chk("sw_addr", result_out, 16'h0103);
    chk("sw_data", store_data_out, 16'hBEEF);
    chk("sw_tgt0", {13'd0, tgt_out}, 16'd0);
    chk("sw_op", {13'd0, opcode_out}, 16'd4);
    instr(3'b110, 3'd3, 3'd1, 3'd2, 16'd9, 16'd9, 16'hFFFE, 16'h0010);
    halt_in_wb = 1'b1;
    #1;
    chk("wbhalt_br", {15'd0, branch_taken}, 16'd0);
    step;
    chk("wbhalt_bubble", {15'd0, bubble_out}, 16'd1);
    halt_in_wb = 1'b0;
    instr(3'b000, 3'd1, 3'd1, 3'd2, 16'd1, 16'd2, 16'd0, 16'd0);
    halt_in = 1'b1;
    step;
    chk("halt_out", {15'd0, halt_out}, 16'd1);
    chk("halt_bubble", {15'd0, bubble_out}, 16'd0);
    halt_in = 1'b0;
    step;
    chk("halted_bubble", {15'd0, bubble_out}, 16'd1);
    chk("halted_halt", {15'd0, halt_out}, 16'd0);
    chk("halted_result", result_out, 16'h0000);
    instr(3'b111, 3'd7, 3'd4, 3'd2, 16'h0000, 16'h1234, 16'd0, 16'h0020);
    mem_bubble = 1'b0; mem_opcode = 3'b101; mem_tgt = 3'd4;
    #1;
    chk("halted_br", {15'd0, branch_taken}, 16'd0);
    chk("halted_stall", {15'd0, stall_out}, 16'd0);
    mem_bubble = 1'b1;
    rst_n = 1'b0;
    step;
    chk("rst2_bubble", {15'd0, bubble_out}, 16'd1);
    rst_n = 1'b1;
    instr(3'b000, 3'd2, 3'd1, 3'd2, 16'h0003, 16'h0004, 16'd0, 16'd0);
    step;
    chk("post_rst_bubble", {15'd0, bubble_out}, 16'd0);
    chk("post_rst_result", result_out, 16'h0007);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
